// File: rtl/cipher_addsub_stream.sv
// cipher_addsub_stream: PASTA keystream combiner, (x + ks) mod q or (x - ks) mod q, LANES words per beat.
// Define CIPHER_ADDSUB_RANGE_CHECK_EN to flag operands >= MODULUS on RangeErr_SO.
module cipher_addsub_stream #(
  parameter int PASTA_S = 32,
  parameter int BITLEN  = 17,
  parameter int MODULUS = 65537,
  parameter int LANES   = 8
) (
  input  logic                      Clk_CI,
  input  logic                      Rst_RI,
  input  logic                      Start_SI,
  input  logic                      Decrypt_SI,
  input  logic [PASTA_S*BITLEN-1:0] InData_DI,
  input  logic [PASTA_S*BITLEN-1:0] Key_DI,
  output logic [PASTA_S*BITLEN-1:0] OutData_DO,
  output logic                      Busy_SO,
  output logic                      Finish_SO,
  output logic                      RangeErr_SO
);
  localparam int BEATS = PASTA_S / LANES;
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam logic [BITLEN:0] Q = (BITLEN+1)'(MODULUS);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state;
  logic [PASTA_S*BITLEN-1:0] in_q, key_q;
  logic dec_q, v0, v1;
  logic [BW-1:0] beat, idx0, idx1;
  logic [LANES-1:0][BITLEN-1:0] a0, b0;
  logic [LANES-1:0][BITLEN:0] s1, s1_n, r2;
  always_comb begin
    s1_n = '0;
    r2 = '0;
    for (int l = 0; l < LANES; l++) begin
      s1_n[l] = dec_q ? {1'b0, a0[l]} - {1'b0, b0[l]} : {1'b0, a0[l]} + {1'b0, b0[l]};
      // sub keeps the borrow in the top bit; add compares the full-width sum
      r2[l] = dec_q ? (s1[l][BITLEN] ? s1[l] + Q : s1[l]) : (s1[l] >= Q ? s1[l] - Q : s1[l]);
    end
  end
  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      state <= IDLE;
      in_q <= '0;
      key_q <= '0;
      dec_q <= 1'b0;
      OutData_DO <= '0;
      Busy_SO <= 1'b0;
      Finish_SO <= 1'b0;
      beat <= '0;
      idx0 <= '0;
      idx1 <= '0;
      v0 <= 1'b0;
      v1 <= 1'b0;
      a0 <= '0;
      b0 <= '0;
      s1 <= '0;
    end else begin
      Finish_SO <= 1'b0;
      v0 <= 1'b0;
      v1 <= v0;
      idx1 <= idx0;
      s1 <= s1_n;
      if (v1)
        for (int l = 0; l < LANES; l++)
          OutData_DO[(int'(idx1)*LANES+l)*BITLEN +: BITLEN] <= r2[l][BITLEN-1:0];
      case (state)
        IDLE: if (Start_SI) begin
          in_q <= InData_DI;
          key_q <= Key_DI;
          dec_q <= Decrypt_SI;
          OutData_DO <= '0;
          Busy_SO <= 1'b1;
          beat <= '0;
          state <= RUN;
        end
        RUN: begin
          v0 <= 1'b1;
          idx0 <= beat;
          for (int l = 0; l < LANES; l++) begin
            a0[l] <= in_q[(int'(beat)*LANES+l)*BITLEN +: BITLEN];
            b0[l] <= key_q[(int'(beat)*LANES+l)*BITLEN +: BITLEN];
          end
          if (beat == BW'(BEATS-1)) state <= DRAIN;
          else beat <= beat + 1'b1;
        end
        DRAIN: if (v1 && !v0) begin
          state <= IDLE;
          Busy_SO <= 1'b0;
          Finish_SO <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef CIPHER_ADDSUB_RANGE_CHECK_EN
  logic oor;
  always_comb begin
    oor = 1'b0;
    for (int l = 0; l < LANES; l++)
      oor = oor | (v0 && ({1'b0, a0[l]} >= Q || {1'b0, b0[l]} >= Q));
  end
  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) RangeErr_SO <= 1'b0;
    else if (state == IDLE && Start_SI) RangeErr_SO <= 1'b0;
    else if (oor) RangeErr_SO <= 1'b1;
  end
`else
  assign RangeErr_SO = 1'b0;
`endif
endmodule

// File: tb/tb_cipher_addsub_stream.sv
// tb_cipher_addsub_stream: directed checks of the PASTA add/sub combiner with default parameters.
module tb_cipher_addsub_stream;
  localparam int S = 32;
  localparam int BL = 17;
  localparam int W = S * BL;
  logic clk = 1'b0;
  logic rst, start, dec, rerr, busy, fin;
  logic [W-1:0] din, key, dout;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  cipher_addsub_stream dut (
    .Clk_CI(clk), .Rst_RI(rst), .Start_SI(start), .Decrypt_SI(dec),
    .InData_DI(din), .Key_DI(key), .OutData_DO(dout),
    .Busy_SO(busy), .Finish_SO(fin), .RangeErr_SO(rerr)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic go(input logic [W-1:0] a, input logic [W-1:0] b, input logic d);
    @(negedge clk);
    din = a;
    key = b;
    dec = d;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    dec = 1'b0;
    din = '1;
    key = '1;
    repeat (3) tick();
    checks++; if (dout !== '0) begin errors++; $display("FAIL reset_out got=%h want=0", dout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (fin !== 1'b0) begin errors++; $display("FAIL reset_finish got=%b want=0", fin); end
    checks++; if (rerr !== 1'b0) begin errors++; $display("FAIL reset_rangeerr got=%b want=0", rerr); end
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_add_wrap();
    logic [W-1:0] a, b;
    for (int i = 0; i < S; i++) begin
      a[i*BL +: BL] = 17'd65536;
      b[i*BL +: BL] = 17'd1;
    end
    go(a, b, 1'b0);
    for (int e = 1; e <= 6; e++) begin
      tick();
      checks++;
      if (fin !== 1'(e == 6)) begin errors++; $display("FAIL wrap_finish_E%0d got=%b want=%b", e, fin, e == 6); end
    end
    checks++; if (dout !== '0) begin errors++; $display("FAIL wrap_out got=%h want=0", dout); end
    tick();
    checks++; if (fin !== 1'b0) begin errors++; $display("FAIL wrap_finish_E7 got=%b want=0", fin); end
  endtask
  task automatic test_sub();
    logic [W-1:0] a, b, e;
    for (int i = 0; i < S; i++) begin
      a[i*BL +: BL] = (i % 3 == 0) ? 17'd0 : (i % 3 == 1) ? 17'd5 : 17'd100;
      b[i*BL +: BL] = (i % 3 == 0) ? 17'd1 : (i % 3 == 1) ? 17'd5 : 17'd30;
      e[i*BL +: BL] = (i % 3 == 0) ? 17'd65536 : (i % 3 == 1) ? 17'd0 : 17'd70;
    end
    go(a, b, 1'b1);
    repeat (6) tick();
    checks++; if (fin !== 1'b1) begin errors++; $display("FAIL sub_finish got=%b want=1", fin); end
    checks++; if (dout !== e) begin errors++; $display("FAIL sub_out got=%h want=%h", dout, e); end
  endtask
  task automatic test_add_index();
    logic [W-1:0] a, b, e, part;
    part = '0;
    for (int i = 0; i < S; i++) begin
      a[i*BL +: BL] = 17'(i);
      b[i*BL +: BL] = 17'(2 * i);
      e[i*BL +: BL] = 17'(3 * i);
      if (i < 8) part[i*BL +: BL] = 17'(3 * i);
    end
    go(a, b, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL idx_busy_E0 got=%b want=1", busy); end
    checks++; if (dout !== '0) begin errors++; $display("FAIL idx_cleared got=%h want=0", dout); end
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++;
      if (busy !== 1'(k < 6)) begin errors++; $display("FAIL idx_busy_E%0d got=%b want=%b", k, busy, k < 6); end
      if (k == 3) begin
        checks++;
        if (dout !== part) begin errors++; $display("FAIL idx_partial_E3 got=%h want=%h", dout, part); end
      end
    end
    checks++; if (fin !== 1'b1) begin errors++; $display("FAIL idx_finish got=%b want=1", fin); end
    checks++; if (dout !== e) begin errors++; $display("FAIL idx_out got=%h want=%h", dout, e); end
    repeat (3) tick();
    checks++; if (dout !== e) begin errors++; $display("FAIL idx_hold got=%h want=%h", dout, e); end
  endtask
  task automatic test_restart_ignored();
    logic [W-1:0] a, b, e;
    for (int i = 0; i < S; i++) begin
      a[i*BL +: BL] = 17'(i);
      b[i*BL +: BL] = 17'(2 * i);
      e[i*BL +: BL] = 17'(3 * i);
    end
    go(a, b, 1'b0);
    tick();
    @(negedge clk);
    din = {S{17'd7}};
    key = {S{17'd3}};
    dec = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    checks++; if (fin !== 1'b1) begin errors++; $display("FAIL ignore_finish got=%b want=1", fin); end
    checks++; if (dout !== e) begin errors++; $display("FAIL ignore_out got=%h want=%h", dout, e); end
  endtask
  task automatic test_back_to_back();
    logic [W-1:0] e2;
    for (int i = 0; i < S; i++) e2[i*BL +: BL] = 17'd4;
    go({S{17'd10}}, {S{17'd20}}, 1'b0);
    repeat (6) tick();
    din = {S{17'd10}};
    key = {S{17'd6}};
    dec = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1 || dout !== '0) begin errors++; $display("FAIL b2b_accept busy=%b out=%h want busy=1 out=0", busy, dout); end
    repeat (5) tick();
    checks++; if (fin !== 1'b0) begin errors++; $display("FAIL b2b_early_finish got=%b want=0", fin); end
    tick();
    checks++; if (fin !== 1'b1) begin errors++; $display("FAIL b2b_finish got=%b want=1", fin); end
    checks++; if (dout !== e2) begin errors++; $display("FAIL b2b_out got=%h want=%h", dout, e2); end
  endtask
  task automatic test_reset_mid();
    int seen;
    seen = 0;
    go({S{17'd9}}, {S{17'd1}}, 1'b0);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    checks++; if (dout !== '0) begin errors++; $display("FAIL midrst_out got=%h want=0", dout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b want=0", busy); end
    tick();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (fin !== 1'b0) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL midrst_finish got=%0d pulses want=0", seen); end
  endtask
  task automatic test_range();
    logic [W-1:0] a;
    logic want;
`ifdef CIPHER_ADDSUB_RANGE_CHECK_EN
    want = 1'b1;
`else
    want = 1'b0;
`endif
    a = '0;
    a[0 +: BL] = 17'd65537;
    go(a, '0, 1'b0);
    tick();
    tick();
    checks++; if (rerr !== want) begin errors++; $display("FAIL range_set_E2 got=%b want=%b", rerr, want); end
    repeat (4) tick();
    checks++; if (rerr !== want) begin errors++; $display("FAIL range_sticky got=%b want=%b", rerr, want); end
    checks++; if (dout !== '0) begin errors++; $display("FAIL range_out got=%h want=0", dout); end
    go({S{17'd1}}, {S{17'd2}}, 1'b0);
    checks++; if (rerr !== 1'b0) begin errors++; $display("FAIL range_clear got=%b want=0", rerr); end
    repeat (6) tick();
    checks++; if (rerr !== 1'b0) begin errors++; $display("FAIL range_clean got=%b want=0", rerr); end
  endtask
  initial begin
    test_reset();
    test_add_wrap();
    test_sub();
    test_add_index();
    test_restart_ignored();
    test_back_to_back();
    test_reset_mid();
    test_range();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
